// File: rtl/toeplitz_pkg.sv
// Shared constants for the Toeplitz hash engine: data width, default block
// size, FSM state codes and the kind of the next expected FIFO word.
package toeplitz_pkg;

   localparam int DATA_W            = 32;
   localparam int MSG_WORDS_DEFAULT = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_CAPT  = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [1:0] {
      KIND_K0  = 2'd0,
      KIND_KEY = 2'd1,
      KIND_MSG = 2'd2
   } word_kind_e;

endpackage

// File: rtl/toeplitz_hash_if.sv
// Upstream FIFO read port plus downstream hash valid/ready handshake.
// The master modport is the hash engine, the slave modport its environment.
interface toeplitz_hash_if;
   import toeplitz_pkg::*;

   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] hash_out;
   logic              hash_valid;
   logic              hash_ready;

   modport master (
      input  fifo_dout, fifo_empty, hash_ready,
      output fifo_rd_en, hash_out, hash_valid
   );

   modport slave (
      output fifo_dout, fifo_empty, hash_ready,
      input  fifo_rd_en, hash_out, hash_valid
   );

endinterface

// File: rtl/toeplitz_shift_core.sv
// Datapath of the Toeplitz hash: 64-bit key window, message shifter,
// hash accumulator and bit counter, sequenced by the FSM in toeplitz_hash.
module toeplitz_shift_core
   import toeplitz_pkg::*;
(
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              load_k0,
   input  logic              load_key,
   input  logic              load_msg,
   input  logic              shift_en,
   input  logic              clear_hash,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] hash,
   output logic              last_bit
);

   logic [2*DATA_W-1:0] window_q, window_d;
   logic [DATA_W-1:0]   msg_q, msg_d;
   logic [DATA_W-1:0]   hash_q, hash_d;
   logic [4:0]          bitcnt_q, bitcnt_d;

   // The upper window half is the 32-bit key slice aligned with the current
   // message bit; shifting pulls the next key word's bits in from below.
   always_comb begin
      window_d = window_q;
      msg_d    = msg_q;
      hash_d   = hash_q;
      bitcnt_d = bitcnt_q;
      if (clear_hash) begin
         hash_d = '0;
      end
      if (load_k0) begin
         window_d[2*DATA_W-1:DATA_W] = data_in;
      end
      if (load_key) begin
         window_d[DATA_W-1:0] = data_in;
      end
      if (load_msg) begin
         msg_d    = data_in;
         bitcnt_d = '0;
      end
      if (shift_en) begin
         if (msg_q[DATA_W-1]) begin
            hash_d = hash_q ^ window_q[2*DATA_W-1:DATA_W];
         end
         window_d = window_q << 1;
         msg_d    = msg_q << 1;
         bitcnt_d = bitcnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         window_q <= '0;
         msg_q    <= '0;
         hash_q   <= '0;
         bitcnt_q <= '0;
      end else begin
         window_q <= window_d;
         msg_q    <= msg_d;
         hash_q   <= hash_d;
         bitcnt_q <= bitcnt_d;
      end
   end

   assign hash     = hash_q;
   assign last_bit = (bitcnt_q == 5'd31);

endmodule

// File: rtl/toeplitz_hash.sv
// Toeplitz hash engine: pulls a seed word then alternating key/message words
// from a FIFO, hashes MSG_WORDS message words, and hands the result downstream.
module toeplitz_hash
   import toeplitz_pkg::*;
#(
   parameter int MSG_WORDS = MSG_WORDS_DEFAULT
)(
   input  logic            clk_in,
   input  logic            rst_n,
   toeplitz_hash_if.master bus,
   output logic            busy,
   output logic [15:0]     block_cnt
);

   localparam logic [3:0] LAST_IDX = 4'(MSG_WORDS - 1);

   logic [2:0]  state_q, state_d;
   word_kind_e  kind_q, kind_d;
   logic [3:0]  index_q, index_d;
   logic [15:0] block_cnt_q, block_cnt_d;

   logic              load_k0, load_key, load_msg, shift_en, clear_hash;
   logic              last_bit;
   logic [DATA_W-1:0] hash;

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      index_d     = index_q;
      block_cnt_d = block_cnt_q;
      load_k0     = 1'b0;
      load_key    = 1'b0;
      load_msg    = 1'b0;
      shift_en    = 1'b0;
      clear_hash  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (!bus.fifo_empty) begin
               state_d = ST_CAPT;
            end
         end
         // After the seed, each key word is always followed by its message word.
         ST_CAPT: begin
            case (kind_q)
               KIND_K0: begin
                  load_k0 = 1'b1;
                  kind_d  = KIND_KEY;
                  state_d = ST_REQ;
               end
               KIND_KEY: begin
                  load_key = 1'b1;
                  kind_d   = KIND_MSG;
                  state_d  = ST_REQ;
               end
               default: begin
                  load_msg = 1'b1;
                  state_d  = ST_SHIFT;
               end
            endcase
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (last_bit) begin
               if (index_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  index_d = index_q + 4'd1;
                  kind_d  = KIND_KEY;
                  state_d = ST_REQ;
               end
            end
         end
         ST_DONE: begin
            if (bus.hash_ready) begin
               block_cnt_d = block_cnt_q + 16'd1;
               clear_hash  = 1'b1;
               index_d     = '0;
               kind_d      = KIND_K0;
               state_d     = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         kind_q      <= KIND_K0;
         index_q     <= '0;
         block_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         index_q     <= index_d;
         block_cnt_q <= block_cnt_d;
      end
   end

   toeplitz_shift_core u_core (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .load_k0    (load_k0),
      .load_key   (load_key),
      .load_msg   (load_msg),
      .shift_en   (shift_en),
      .clear_hash (clear_hash),
      .data_in    (bus.fifo_dout),
      .hash       (hash),
      .last_bit   (last_bit)
   );

   // The partial hash stays internal; only a finished hash is presented.
   assign bus.fifo_rd_en = (state_q == ST_REQ) && !bus.fifo_empty;
   assign bus.hash_valid = (state_q == ST_DONE);
   assign bus.hash_out   = (state_q == ST_DONE) ? hash : '0;
   assign busy           = (state_q != ST_IDLE);
   assign block_cnt      = block_cnt_q;

endmodule

// File: tb/tb_toeplitz_hash.sv
// Self-checking bench for toeplitz_hash: a one-word and a default-size
// instance fed from queue-modelled FIFOs, checked against a bit-level model.
module tb_toeplitz_hash;
   import toeplitz_pkg::*;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic        rst1_n, rst4_n;
   logic        busy1, busy4;
   logic [15:0] cnt1, cnt4;

   toeplitz_hash_if bus1 ();
   toeplitz_hash_if bus4 ();

   toeplitz_hash #(.MSG_WORDS(1)) dut1 (
      .clk_in    (clk_in),
      .rst_n     (rst1_n),
      .bus       (bus1),
      .busy      (busy1),
      .block_cnt (cnt1)
   );

   toeplitz_hash dut4 (
      .clk_in    (clk_in),
      .rst_n     (rst4_n),
      .bus       (bus4),
      .busy      (busy4),
      .block_cnt (cnt4)
   );

   logic [31:0] q1[$];
   logic [31:0] q4[$];
   logic [31:0] blk_a[$];
   logic [31:0] exp_a;
   logic        stall4;
   int          checks, failures;
   int          cycle_no, first_rd4, rd4_pulses, rd_on_empty;
   logic [15:0] exp_cnt1;

   // Toeplitz hash by definition: key bit string K0 K1 .. Kw, message bit j
   // (MSB first across words) selects key bits j .. j+31 for XOR into the result.
   function automatic logic [31:0] ref_hash(input logic [31:0] s[$], input int w);
      logic [31:0] keys[16];
      logic [31:0] msgs[16];
      logic [31:0] r;
      r = '0;
      keys[0] = s[0];
      for (int k = 1; k <= w; k++) keys[k] = s[2*k-1];
      for (int n = 0; n < w; n++) msgs[n] = s[2*n+2];
      for (int j = 0; j < 32*w; j++) begin
         if (msgs[j/32][31 - (j%32)]) begin
            for (int b = 0; b < 32; b++) begin
               int p;
               p = j + b;
               r[31-b] = r[31-b] ^ keys[p/32][31 - (p%32)];
            end
         end
      end
      return r;
   endfunction

   // One clock cycle, entered and left at a falling edge; models both FIFOs.
   task automatic tick();
      logic rd1, rd4;
      bus1.fifo_empty = (q1.size() == 0);
      bus4.fifo_empty = stall4 || (q4.size() == 0);
      #1;
      rd1 = bus1.fifo_rd_en;
      rd4 = bus4.fifo_rd_en;
      if ((rd1 && bus1.fifo_empty) || (rd4 && bus4.fifo_empty)) rd_on_empty++;
      if (rd4) begin
         rd4_pulses++;
         if (first_rd4 < 0) first_rd4 = cycle_no;
      end
      @(posedge clk_in);
      #1;
      if (rd1 && q1.size() > 0) bus1.fifo_dout = q1.pop_front();
      if (rd4 && q4.size() > 0) bus4.fifo_dout = q4.pop_front();
      cycle_no++;
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      @(negedge clk_in);
      checks++;
      if (bus1.hash_out !== 32'h0 || bus1.hash_valid !== 1'b0 || busy1 !== 1'b0 ||
          cnt1 !== 16'h0 || bus1.fifo_rd_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_dut1: out=%h valid=%b busy=%b cnt=%h rd=%b, required all zero",
                  bus1.hash_out, bus1.hash_valid, busy1, cnt1, bus1.fifo_rd_en);
      end
      checks++;
      if (bus4.hash_out !== 32'h0 || bus4.hash_valid !== 1'b0 || busy4 !== 1'b0 ||
          cnt4 !== 16'h0 || bus4.fifo_rd_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_dut4: out=%h valid=%b busy=%b cnt=%h rd=%b, required all zero",
                  bus4.hash_out, bus4.hash_valid, busy4, cnt4, bus4.fifo_rd_en);
      end
      rst1_n = 1'b1;
      rst4_n = 1'b1;
      tick();
      checks++;
      if (busy1 !== 1'b1 || busy4 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_release_busy: busy1=%b busy4=%b, required 1 1", busy1, busy4);
      end
   endtask

   task automatic test_directed_w1();
      logic [31:0] vk0[3], vk1[3], vm0[3], vexp[3];
      int n;
      vk0[0] = 32'hDEADBEEF; vk1[0] = 32'h0; vm0[0] = 32'h80000000; vexp[0] = 32'hDEADBEEF;
      vk0[1] = 32'h00000001; vk1[1] = 32'h0; vm0[1] = 32'h00000001; vexp[1] = 32'h80000000;
      vk0[2] = 32'hFFFFFFFF; vk1[2] = 32'hFFFFFFFF; vm0[2] = 32'hFFFFFFFF; vexp[2] = 32'h0;
      bus1.hash_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         q1.push_back(vk0[i]);
         q1.push_back(vk1[i]);
         q1.push_back(vm0[i]);
         n = 0;
         while (bus1.hash_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
         end
         checks++;
         if (bus1.hash_valid !== 1'b1 || bus1.hash_out !== vexp[i]) begin
            failures++;
            $display("[TB] FAIL directed_hash[%0d]: valid=%b hash=%h, required valid=1 hash=%h",
                     i, bus1.hash_valid, bus1.hash_out, vexp[i]);
         end
         tick();
         exp_cnt1 = exp_cnt1 + 16'd1;
         checks++;
         if (cnt1 !== exp_cnt1) begin
            failures++;
            $display("[TB] FAIL directed_cnt[%0d]: block_cnt=%0d, required %0d", i, cnt1, exp_cnt1);
         end
      end
      bus1.hash_ready = 1'b0;
   endtask

   task automatic test_latency_hold();
      int n, lat, pulses;
      blk_a = {};
      for (int i = 0; i < 9; i++) begin
         blk_a.push_back($urandom());
         q4.push_back(blk_a[i]);
      end
      exp_a = ref_hash(blk_a, MSG_WORDS_DEFAULT);
      bus4.hash_ready = 1'b0;
      first_rd4 = -1;
      n = 0;
      while (bus4.hash_valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      lat = cycle_no - first_rd4;
      checks++;
      if (bus4.hash_valid !== 1'b1 || lat != 2 + 36*MSG_WORDS_DEFAULT) begin
         failures++;
         $display("[TB] FAIL latency: valid=%b after %0d cycles, required valid=1 after %0d",
                  bus4.hash_valid, lat, 2 + 36*MSG_WORDS_DEFAULT);
      end
      checks++;
      if (bus4.hash_out !== exp_a) begin
         failures++;
         $display("[TB] FAIL block_hash: hash=%h, required %h", bus4.hash_out, exp_a);
      end
      for (int i = 0; i < 3; i++) q4.push_back(blk_a[i]);
      pulses = rd4_pulses;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bus4.hash_valid !== 1'b1 || bus4.hash_out !== exp_a || bus4.fifo_rd_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold[%0d]: valid=%b hash=%h rd=%b, required 1 %h 0",
                     i, bus4.hash_valid, bus4.hash_out, bus4.fifo_rd_en, exp_a);
         end
      end
      checks++;
      if (rd4_pulses != pulses) begin
         failures++;
         $display("[TB] FAIL hold_reads: %0d reads while done, required 0", rd4_pulses - pulses);
      end
      bus4.hash_ready = 1'b1;
      tick();
      bus4.hash_ready = 1'b0;
      checks++;
      if (cnt4 !== 16'd1 || bus4.hash_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL accept: cnt=%0d valid=%b, required 1 0", cnt4, bus4.hash_valid);
      end
   endtask

   task automatic test_stall();
      int n, pulses, bad;
      n = 0;
      while (q4.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      bus4.hash_ready = 1'b1;
      pulses = rd4_pulses;
      bad    = rd_on_empty;
      for (int i = 0; i < 60; i++) tick();
      checks++;
      if (rd4_pulses != pulses || rd_on_empty != bad) begin
         failures++;
         $display("[TB] FAIL stall_reads: reads=%0d reads_on_empty=%0d, required 0 0",
                  rd4_pulses - pulses, rd_on_empty - bad);
      end
      checks++;
      if (busy4 !== 1'b1 || bus4.hash_valid !== 1'b0 || cnt4 !== 16'd1) begin
         failures++;
         $display("[TB] FAIL stall_state: busy=%b valid=%b cnt=%0d, required 1 0 1",
                  busy4, bus4.hash_valid, cnt4);
      end
      for (int i = 3; i < 9; i++) q4.push_back(blk_a[i]);
      n = 0;
      while (bus4.hash_valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (bus4.hash_valid !== 1'b1 || bus4.hash_out !== exp_a) begin
         failures++;
         $display("[TB] FAIL stall_hash: valid=%b hash=%h, required 1 %h",
                  bus4.hash_valid, bus4.hash_out, exp_a);
      end
      tick();
      bus4.hash_ready = 1'b0;
      checks++;
      if (cnt4 !== 16'd2) begin
         failures++;
         $display("[TB] FAIL stall_cnt: block_cnt=%0d, required 2", cnt4);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] blk[$];
      logic [31:0] w, exp;
      int n, base;
      for (int i = 0; i < 9; i++) q4.push_back($urandom());
      bus4.hash_ready = 1'b0;
      base = rd4_pulses;
      n = 0;
      while (rd4_pulses < base + 5 && n < 200) begin
         tick();
         n++;
      end
      for (int i = 0; i < 10; i++) tick();
      #2;
      rst4_n = 1'b0;
      #1;
      checks++;
      if (bus4.hash_out !== 32'h0 || bus4.hash_valid !== 1'b0 || busy4 !== 1'b0 ||
          cnt4 !== 16'h0 || bus4.fifo_rd_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs: out=%h valid=%b busy=%b cnt=%h rd=%b, required all zero",
                  bus4.hash_out, bus4.hash_valid, busy4, cnt4, bus4.fifo_rd_en);
      end
      checks++;
      if (q4.size() != 4) begin
         failures++;
         $display("[TB] FAIL midreset_words_read: %0d words left, required 4", q4.size());
      end
      @(negedge clk_in);
      rst4_n = 1'b1;
      blk = q4;
      for (int i = 0; i < 5; i++) begin
         w = $urandom();
         blk.push_back(w);
         q4.push_back(w);
      end
      exp = ref_hash(blk, MSG_WORDS_DEFAULT);
      bus4.hash_ready = 1'b1;
      n = 0;
      while (bus4.hash_valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (bus4.hash_valid !== 1'b1 || bus4.hash_out !== exp) begin
         failures++;
         $display("[TB] FAIL midreset_hash: valid=%b hash=%h, required 1 %h",
                  bus4.hash_valid, bus4.hash_out, exp);
      end
      tick();
      bus4.hash_ready = 1'b0;
      checks++;
      if (cnt4 !== 16'd1) begin
         failures++;
         $display("[TB] FAIL midreset_cnt: block_cnt=%0d, required 1", cnt4);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] all[$];
      logic [31:0] blk[$];
      logic [31:0] exp;
      int n, hold;
      for (int i = 0; i < 12; i++) begin
         all.push_back($urandom());
         q1.push_back(all[i]);
      end
      for (int b = 0; b < 4; b++) begin
         blk = {};
         for (int i = 0; i < 3; i++) blk.push_back(all[3*b+i]);
         exp = ref_hash(blk, 1);
         n = 0;
         while (bus1.hash_valid !== 1'b1 && n < 200) begin
            bus1.hash_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
         bus1.hash_ready = 1'b0;
         checks++;
         if (bus1.hash_valid !== 1'b1 || bus1.hash_out !== exp) begin
            failures++;
            $display("[TB] FAIL b2b_hash[%0d]: valid=%b hash=%h, required 1 %h",
                     b, bus1.hash_valid, bus1.hash_out, exp);
         end
         hold = $urandom_range(0, 3);
         for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (bus1.hash_valid !== 1'b1 || bus1.hash_out !== exp || bus1.fifo_rd_en !== 1'b0) begin
               failures++;
               $display("[TB] FAIL b2b_hold[%0d]: valid=%b hash=%h rd=%b, required 1 %h 0",
                        b, bus1.hash_valid, bus1.hash_out, bus1.fifo_rd_en, exp);
            end
         end
         bus1.hash_ready = 1'b1;
         tick();
         bus1.hash_ready = 1'b0;
         exp_cnt1 = exp_cnt1 + 16'd1;
         checks++;
         if (cnt1 !== exp_cnt1) begin
            failures++;
            $display("[TB] FAIL b2b_cnt[%0d]: block_cnt=%0d, required %0d", b, cnt1, exp_cnt1);
         end
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      cycle_no    = 0;
      first_rd4   = -1;
      rd4_pulses  = 0;
      rd_on_empty = 0;
      exp_cnt1    = 16'd0;
      stall4      = 1'b0;
      rst1_n      = 1'b1;
      rst4_n      = 1'b1;
      bus1.fifo_dout  = 32'h0;
      bus1.fifo_empty = 1'b1;
      bus1.hash_ready = 1'b0;
      bus4.fifo_dout  = 32'h0;
      bus4.fifo_empty = 1'b1;
      bus4.hash_ready = 1'b0;
      #1;
      rst1_n = 1'b0;
      rst4_n = 1'b0;
      test_reset();
      test_directed_w1();
      test_latency_hold();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/toeplitz_hash.md
TOEPLITZ_HASH -- requirements
Module: toeplitz_hash

Interface
REQ-001 Parameter MSG_WORDS, default 4, number of 32-bit message words per hash block (legal 1..15).
REQ-002 clk_in  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 fifo_dout  input  32  upstream FIFO read data, valid the cycle after fifo_rd_en.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_rd_en  output  1  upstream FIFO read strobe.
REQ-007 hash_out  output  32  Toeplitz hash of the completed block.
REQ-008 hash_valid  output  1  hash_out valid; held until accepted.
REQ-009 hash_ready  input  1  downstream accepts hash when high with hash_valid.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 block_cnt  output  16  count of accepted hashes, wraps 0xFFFF->0x0000.

Function
REQ-012 Input stream per block SHALL be K0, K1, M0, K2, M1, ..., K(MSG_WORDS), M(MSG_WORDS-1): one seed word, then alternating key/message words.
REQ-013 fifo_rd_en SHALL be combinational: (state==REQ) && !fifo_empty; never asserted while fifo_empty is high.
REQ-014 States: IDLE, REQ, CAPT, SHIFT, DONE; IDLE->REQ unconditionally one cycle after reset release.
REQ-015 REQ: stay while fifo_empty; else assert fifo_rd_en, go CAPT.
REQ-016 CAPT: sample fifo_dout by word kind -- K0 into window[63:32], Kn into window[31:0], Mn into msg; after K0 or Kn go REQ, after Mn go SHIFT with bitcnt=0.
REQ-017 SHIFT, one message bit per cycle, MSB first: if msg[31] then hash ^= window[63:32]; window <<= 1; msg <<= 1; bitcnt++ (5-bit).
REQ-018 At bitcnt==31 in SHIFT: if word index == MSG_WORDS-1 go DONE, else index++, kind=key, go REQ.
REQ-019 DONE: hash_out = hash register, hash_valid=1; on hash_ready: block_cnt++, clear hash, index=0, kind=K0, go REQ.
REQ-020 hash_out and hash_valid SHALL remain stable while hash_valid && !hash_ready; no FIFO reads in DONE.
REQ-021 Latency, FIFO never empty: hash_valid asserts 2+36*MSG_WORDS cycles after the first fifo_rd_en cycle (146 for default).
REQ-022 fifo_empty rising mid-block SHALL only stall in REQ; captured/shifted state and partial hash are preserved.
REQ-023 hash_ready asserted outside DONE SHALL be ignored.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, fifo_rd_en=0, hash_out=0, hash_valid=0, busy=0, block_cnt=0, window/msg/hash/bitcnt/index=0, kind=K0.
REQ-025 Reset mid-block SHALL discard the partial block; the next block starts with the next FIFO word treated as K0.

Structure
REQ-026 Shared package toeplitz_pkg SHALL hold state encodings, word-kind encodings (K0, KEY, MSG), data width 32 and the MSG_WORDS default.
REQ-027 One sub-module toeplitz_shift_core SHALL hold window, msg, hash and bitcnt; the FSM and handshakes stay in toeplitz_hash.

Verification
REQ-028 MSG_WORDS=1, feed K0=0xDEADBEEF, K1=0x00000000, M0=0x80000000, hash_ready=1 -> hash_out=0xDEADBEEF, block_cnt=1.
REQ-029 MSG_WORDS=1, K0=0x00000001, K1=0x00000000, M0=0x00000001 -> hash_out=0x80000000.
REQ-030 MSG_WORDS=1, K0=K1=M0=0xFFFFFFFF -> hash_out=0x00000000 (32 XORs cancel).
REQ-031 Default MSG_WORDS, FIFO preloaded with 9 words -> hash_valid 146 cycles after first fifo_rd_en; hold hash_ready=0 for 10 cycles -> hash_out stable, fifo_rd_en=0 throughout.
REQ-032 Drive fifo_empty=1 for 20 cycles between M0 and K2 -> fifo_rd_en stays 0, final hash identical to the no-stall run.
REQ-033 Pulse rst_n low during SHIFT of M1 -> all outputs zero immediately; next complete block hashes correctly from a fresh K0.
